// File: rtl/fp16_mult_arb_pkg.sv
// Shared types and helpers for the fp16 multiplier arbiter: operand bundle,
// round-robin pick and the truncating fp16 multiply.
package fp16_mult_arb_pkg;

  typedef logic [15:0] fp16_t;

  localparam int    MAX_REQ   = 16;
  localparam int    MAX_ID_W  = 4;
  localparam fp16_t FP16_ZERO = 16'h0000;

  typedef struct packed {
    fp16_t                a;
    fp16_t                b;
    logic [MAX_ID_W-1:0]  id;
  } op_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // Zero exponent is treated as zero; mantissa is truncated; exponent
  // underflow flushes to zero; overflow wraps (no Inf/NaN handling).
  function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
    logic        sign;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [21:0] prod;
    logic [6:0]  esum;
    logic [9:0]  mant;
    fp16_t       r;
    sign = a[15] ^ b[15];
    ea   = a[14:10];
    eb   = b[14:10];
    prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    if (prod[21]) begin
      mant = prod[20:11];
      esum = 7'(ea) + 7'(eb) + 7'd1;
    end else begin
      mant = prod[19:10];
      esum = 7'(ea) + 7'(eb);
    end
    if (ea == 5'd0 || eb == 5'd0) r = FP16_ZERO;
    else if (esum <= 7'd15)       r = FP16_ZERO;
    else                          r = {sign, 5'(esum - 7'd15), mant};
    return r;
  endfunction

  // First valid requester at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int n);
    pick_t             p;
    logic [MAX_ID_W:0] idx;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = {1'b0, ptr} + 5'(k);
        if (idx >= 5'(n)) idx = idx - 5'(n);
        if (valid[idx[MAX_ID_W-1:0]]) begin
          p.found = 1'b1;
          p.idx   = idx[MAX_ID_W-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fp16_mult_arbiter_pipe.sv
// Fixed-latency fp16 multiply pipeline; never stalls, carries valid and id.
module fp16_mult_pipe
  import fp16_mult_arb_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  op_t                 op,
  output logic                res_valid,
  output fp16_t               res_data,
  output logic [MAX_ID_W-1:0] res_id,
  output logic                active
);

  logic [MULT_LAT-1:0] vld;
  fp16_t               data [MULT_LAT];
  logic [MAX_ID_W-1:0] id   [MULT_LAT];

  // The product is formed at stage 0; later stages only delay it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        data[s] <= FP16_ZERO;
        id[s]   <= '0;
      end
    end else begin
      vld[0] <= op_valid;
      if (op_valid) begin
        data[0] <= fp16_mul(op.a, op.b);
        id[0]   <= op.id;
      end
      for (int s = 1; s < MULT_LAT; s++) begin
        vld[s]  <= vld[s-1];
        data[s] <= data[s-1];
        id[s]   <= id[s-1];
      end
    end
  end

  assign res_valid = vld[MULT_LAT-1];
  assign res_data  = data[MULT_LAT-1];
  assign res_id    = id[MULT_LAT-1];
  assign active    = |vld;

endmodule

// File: rtl/fp16_mult_arbiter.sv
// Round-robin sharing of one pipelined fp16 multiplier among NUM_REQ
// requesters; results return tagged with requester id through a credit-gated FIFO.
module fp16_mult_arbiter
  import fp16_mult_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  MULT_LAT   = 2,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // req_ready is one-hot or zero and never looks at rsp_ready; rsp_* stays
  // stable while rsp_valid && !rsp_ready.

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rr_next;
  logic [CRED_W-1:0]   credits;
  logic [MAX_REQ-1:0]  valid_ext;
  pick_t               pick;
  op_t                 issue_op;
  logic                issue;
  logic                push;
  logic                pop;
  logic                pipe_active;
  fp16_t               res_data;
  logic [MAX_ID_W-1:0] res_id;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
  end

  assign pick  = rr_pick(valid_ext, MAX_ID_W'(rr_ptr), NUM_REQ);
  assign issue = pick.found && (credits != '0) && !rst;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[pick.idx[ID_W-1:0]] = 1'b1;
  end

  always_comb begin
    issue_op    = '0;
    issue_op.id = pick.idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.idx == MAX_ID_W'(i)) begin
        issue_op.a = req_a[16*i +: 16];
        issue_op.b = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    if (32'(pick.idx) == NUM_REQ - 1) rr_next = '0;
    else                              rr_next = ID_W'(pick.idx + 4'd1);
  end

  // Credits cover FIFO slots plus ops still in the pipe, so pushes never overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      credits <= CRED_W'(FIFO_DEPTH);
    end else begin
      if (issue) rr_ptr <= rr_next;
      if (issue && !pop)      credits <= credits - 1'b1;
      else if (pop && !issue) credits <= credits + 1'b1;
    end
  end

  fp16_mult_pipe #(.MULT_LAT(MULT_LAT)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (issue),
    .op        (issue_op),
    .res_valid (push),
    .res_data  (res_data),
    .res_id    (res_id),
    .active    (pipe_active)
  );

  fp16_t             fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CRED_W-1:0] count;

  function automatic logic [PTR_W-1:0] fifo_next(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= fifo_next(wr_ptr);
      if (pop)  rd_ptr <= fifo_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= res_data;
      fifo_id[wr_ptr]   <= res_id[ID_W-1:0];
    end
  end

  assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : FP16_ZERO;
  assign rsp_id   = rsp_valid ? fifo_id[rd_ptr]   : '0;
  assign busy     = pipe_active || rsp_valid;

  logic unused_id_bits;
  assign unused_id_bits = ^{pick.idx, res_id};

endmodule
